// File: rtl/s2p_pkg.sv
// s2p_pkg: shared constants, types and helpers for the s2p deserializer.
// Optional feature macro: S2P_PARITY_EN (adds the even-parity helper).
package s2p_pkg;

   localparam int S2P_N_DEF = 8;

   // Counter width for an N-bit word; N+1 values so parity mode can count the
   // trailing parity bit.
   function automatic int s2p_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   typedef logic [$clog2(S2P_N_DEF + 1)-1:0] s2p_cnt_t;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } s2p_state_t;

`ifdef S2P_PARITY_EN
   // Even parity over a word (zero-extended to 64 bits by the caller).
   function automatic logic s2p_parity(input logic [63:0] w);
      return ^w;
   endfunction
`endif

endpackage

// File: rtl/s2p_shift.sv
// s2p_shift: serial shift register plus bit counter.
//   clk, rst         clock, synchronous active-high reset
//   bit_i, take_i    serial bit and its accept strobe
//   word_done_o      this accept completes a word
//   word_nxt_o       word including the bit being accepted this cycle
//   word_q_o         registered word (used while the top holds a full word)
//   par_nxt_o/par_q_o  received parity bit (only with S2P_PARITY_EN)
// Optional feature macro: S2P_PARITY_EN (one extra parity bit per word).
module s2p_shift
   import s2p_pkg::*;
#(
   parameter int N         = S2P_N_DEF,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bit_i,
   input  logic         take_i,
   output logic         word_done_o,
   output logic [N-1:0] word_nxt_o,
   output logic [N-1:0] word_q_o
`ifdef S2P_PARITY_EN
   ,
   output logic         par_nxt_o,
   output logic         par_q_o
`endif
);

   localparam int CW = s2p_cnt_w(N);
`ifdef S2P_PARITY_EN
   localparam logic [CW-1:0] LAST = CW'(N);
`else
   localparam logic [CW-1:0] LAST = CW'(N - 1);
`endif

   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  sr_q, sr_d;
`ifdef S2P_PARITY_EN
   logic          par_q, par_d;
`endif

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
`ifdef S2P_PARITY_EN
      par_d = par_q;
`endif
      if (take_i) begin
         // Counter wraps on the last bit even if the top must hold the word;
         // s_ready is low while holding, so no bits can overwrite it.
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
         for (int i = 0; i < N; i++) begin
            if (int'(cnt_q) == (LSB_FIRST ? i : N - 1 - i)) sr_d[i] = bit_i;
         end
`ifdef S2P_PARITY_EN
         if (cnt_q == LAST) par_d = bit_i;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sr_q  <= '0;
`ifdef S2P_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
`ifdef S2P_PARITY_EN
         par_q <= par_d;
`endif
      end
   end

   assign word_done_o = take_i & (cnt_q == LAST);
   assign word_nxt_o  = sr_d;
   assign word_q_o    = sr_q;
`ifdef S2P_PARITY_EN
   assign par_nxt_o   = par_d;
   assign par_q_o     = par_q;
`endif

endmodule

// File: rtl/s2p.sv
// s2p: serial-to-parallel deserializer with a two-deep buffer
// (shift register + output register).
//   clk, rst                  clock, synchronous active-high reset
//   s_data, s_valid, s_ready  serial valid/ready input
//   m_data, m_valid, m_ready  parallel valid/ready output
//   parity_err                parity mismatch, valid with m_valid (S2P_PARITY_EN only)
// Optional feature macro: S2P_PARITY_EN.
//
// state      | meaning
// ST_COLLECT | shift register collecting bits, s_ready=1
// ST_HOLD    | shift register holds a complete word waiting for out_reg
module s2p
   import s2p_pkg::*;
#(
   parameter int N         = S2P_N_DEF,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_data,
   input  logic         s_valid,
   output logic         s_ready,
   output logic [N-1:0] m_data,
   output logic         m_valid,
   input  logic         m_ready
`ifdef S2P_PARITY_EN
   ,
   output logic         parity_err
`endif
);

   s2p_state_t   state_q, state_d;
   logic [N-1:0] out_q, out_d;
   logic         mv_q, mv_d;
`ifdef S2P_PARITY_EN
   logic         perr_q, perr_d;
   logic         par_nxt, par_q;
`endif

   logic         accept, drain, out_free, word_done;
   logic [N-1:0] word_nxt, word_q;

   // s_ready comes only from the state register; rst gating keeps all
   // outputs low during the reset cycle.
   assign s_ready  = (state_q == ST_COLLECT) & ~rst;
   assign accept   = s_valid & s_ready;
   assign drain    = mv_q & m_ready;
   assign out_free = ~mv_q | m_ready;

   s2p_shift #(
      .N         (N),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift (
      .clk         (clk),
      .rst         (rst),
      .bit_i       (s_data),
      .take_i      (accept),
      .word_done_o (word_done),
      .word_nxt_o  (word_nxt),
      .word_q_o    (word_q)
`ifdef S2P_PARITY_EN
      ,
      .par_nxt_o   (par_nxt),
      .par_q_o     (par_q)
`endif
   );

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      mv_d    = mv_q;
`ifdef S2P_PARITY_EN
      perr_d  = perr_q;
`endif
      if (drain) mv_d = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (word_done) begin
               if (out_free) begin
                  out_d  = word_nxt;
                  mv_d   = 1'b1;
`ifdef S2P_PARITY_EN
                  perr_d = par_nxt ^ s2p_parity(64'(word_nxt));
`endif
               end else begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_free) begin
               out_d   = word_q;
               mv_d    = 1'b1;
               state_d = ST_COLLECT;
`ifdef S2P_PARITY_EN
               perr_d  = par_q ^ s2p_parity(64'(word_q));
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_COLLECT;
         out_q   <= '0;
         mv_q    <= 1'b0;
`ifdef S2P_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         mv_q    <= mv_d;
`ifdef S2P_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign m_data  = out_q;
   assign m_valid = mv_q;
`ifdef S2P_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_s2p.sv
// tb_s2p: bench for s2p. Two instances share the serial stream: dut (LSB
// first, fully scoreboarded) and dut_b (MSB first, directed checks).
module tb_s2p;

   localparam int N = 8;
`ifdef S2P_PARITY_EN
   localparam int BPW = N + 1;
`else
   localparam int BPW = N;
`endif

   logic         clk = 1'b0;
   logic         rst, s_data, s_valid, m_ready;
   logic         s_ready, m_valid, s_ready_b, m_valid_b;
   logic [N-1:0] m_data, m_data_b;
`ifdef S2P_PARITY_EN
   logic         perr, perr_b;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit rand_mr = 0;

   logic         bitq[$];
   logic [N:0]   expq[$];

   always #5 clk = ~clk;

   s2p #(.N(N), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef S2P_PARITY_EN
      , .parity_err(perr)
`endif
   );

   s2p #(.N(N), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
      .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready)
`ifdef S2P_PARITY_EN
      , .parity_err(perr_b)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with reference-model update. acc reports whether the bit on
   // s_data was accepted at this edge.
   task automatic tick_acc(output logic acc);
      logic p_rst, p_acc, p_bit, p_mv, p_mr, p_pe;
      logic [N-1:0] p_md, w;
      logic [N:0]   e;
      if (rand_mr) m_ready = 1'($urandom_range(0, 1));
      #1;
      p_rst = rst;
      p_acc = s_valid & s_ready;
      p_bit = s_data;
      p_mv  = m_valid;
      p_mr  = m_ready;
      p_md  = m_data;
`ifdef S2P_PARITY_EN
      p_pe  = perr;
`else
      p_pe  = 1'b0;
`endif
      @(posedge clk);
      #1;
      acc = p_acc;
      if (p_rst === 1'b1) begin
         bitq.delete();
         expq.delete();
      end else begin
         if (p_mv && p_mr) begin
            if (expq.size() == 0) check("drain_unexpected", 32'd1, 32'd0);
            else begin
               e = expq.pop_front();
               check("drain_word", 32'({p_pe, p_md}), 32'(e));
            end
         end
         if (p_mv && !p_mr) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(p_md));
         end
         if (p_acc) begin
            bitq.push_back(p_bit);
            if (bitq.size() == BPW) begin
               for (int i = 0; i < N; i++) w[i] = bitq[i];
               e = {1'b0, w};
`ifdef S2P_PARITY_EN
               e[N] = bitq[N] ^ (^w);
`endif
               expq.push_back(e);
               bitq.delete();
            end
         end
         check("m_valid_occ", 32'(m_valid), 32'(expq.size() > 0));
         check("s_ready_occ", 32'(s_ready), 32'(expq.size() < 2));
      end
   endtask

   task automatic tick();
      logic a;
      tick_acc(a);
   endtask

   task automatic send_bit(input logic b, input bit gaps);
      logic a;
      if (gaps) begin
         for (int g = 0; g < 3; g++) begin
            if ($urandom_range(0, 1) == 0) break;
            s_valid = 1'b0;
            tick();
         end
      end
      s_data  = b;
      s_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         tick_acc(a);
         if (a) break;
         if (t == 199) check("s_ready_timeout", 32'd0, 32'd1);
      end
   endtask

   // Sends a word LSB first on the wire; flip corrupts the parity bit.
   task automatic send_word(input logic [N-1:0] w, input bit gaps, input bit flip);
      for (int i = 0; i < N; i++) send_bit(w[i], gaps);
`ifdef S2P_PARITY_EN
      send_bit((^w) ^ flip, gaps);
`else
      if (flip) check("flip_unsupported", 32'd0, 32'd0 + 32'(flip));
`endif
      s_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; s_data = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_m_valid", 32'(m_valid), 32'd0);
      check("reset_m_data", 32'(m_data), 32'd0);
      check("reset_s_ready", 32'(s_ready), 32'd1);

      // back-to-back word, latency and single-cycle m_valid
      m_ready = 1'b1;
      send_word(8'd62, 1'b0, 1'b0);
      check("t1_valid", 32'(m_valid), 32'd1);
      check("t1_data", 32'(m_data), 32'd62);
      check("t2_msb_data", 32'(m_data_b), 32'h7C);
      tick();
      check("t1_valid_pulse", 32'(m_valid), 32'd0);

      // backpressure: two words buffered
      m_ready = 1'b0;
      send_word(8'd52, 1'b0, 1'b0);
      check("t3_first", 32'(m_data), 32'd52);
      send_word(8'd7, 1'b0, 1'b0);
      check("t3_s_ready_low", 32'(s_ready), 32'd0);
      check("t3_held", 32'(m_data), 32'd52);
      tick(); tick(); tick();
      check("t3_still_held", 32'(m_data), 32'd52);
      m_ready = 1'b1;
      tick();
      check("t3_second_valid", 32'(m_valid), 32'd1);
      check("t3_second_data", 32'(m_data), 32'd7);
      check("t3_s_ready_back", 32'(s_ready), 32'd1);
      tick();
      check("t3_empty", 32'(m_valid), 32'd0);

      // gaps on s_valid
      send_word(8'd62, 1'b1, 1'b0);
      check("t4_data", 32'(m_data), 32'd62);
      tick();

      // reset mid-word
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      s_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("t5_rst_m_valid", 32'(m_valid), 32'd0);
      check("t5_rst_m_data", 32'(m_data), 32'd0);
      check("t5_rst_s_ready", 32'(s_ready), 32'd0);
`ifdef S2P_PARITY_EN
      check("t5_rst_perr", 32'(perr), 32'd0);
`endif
      rst = 1'b0;
      send_word(8'd7, 1'b0, 1'b0);
      check("t5_data", 32'(m_data), 32'd7);
      check("t5_msb_data", 32'(m_data_b), 32'hE0);
      tick();

`ifdef S2P_PARITY_EN
      send_word(8'd7, 1'b0, 1'b0);
      check("t6_parity_ok", 32'(perr), 32'd0);
      tick();
      send_word(8'd7, 1'b0, 1'b1);
      check("t6_parity_bad", 32'(perr), 32'd1);
      check("t6_parity_bad_b", 32'(perr_b), 32'd1);
      tick();
`endif
      send_word(8'd62, 1'b0, 1'b0);
      send_word(8'd52, 1'b0, 1'b0);
      tick();

      // randomized words, gaps and backpressure
      rand_mr = 1'b1;
      for (int k = 0; k < 40; k++) begin
`ifdef S2P_PARITY_EN
         send_word(N'($urandom), 1'b1, 1'($urandom_range(0, 1)));
`else
         send_word(N'($urandom), 1'b1, 1'b0);
`endif
      end
      rand_mr = 1'b0;
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check("final_empty", 32'(m_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
